// File: rtl/sample_frame_pack.sv
// rtl/sample_frame_pack.sv - capture a burst of sample bytes, then emit it as a framed stream
// Frame: header(2) | length(2, big-endian) | payload | 8-bit additive checksum.
module sample_frame_pack #(
    parameter int          P_RECV_LEN = 1000,
    parameter logic [15:0] P_HEAD     = 16'h55AA
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_sam_start,
    input  logic [7:0] i_sam_data,
    input  logic       i_sam_data_vld,
    input  logic       i_sam_data_last,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ovf
);
    localparam int          ADDR_W   = (P_RECV_LEN > 1) ? $clog2(P_RECV_LEN) : 1;
    localparam logic [12:0] RECV_LEN = 13'(P_RECV_LEN);

    typedef enum logic [2:0] {
        IDLE, RECV, HEAD0, HEAD1, LEN_H, LEN_L, DATA, SUM
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [12:0]       count;
    logic [12:0]       count_inc;
    logic [12:0]       tx_idx;
    logic [12:0]       tx_idx_inc;
    logic [7:0]        checksum;
    logic [7:0]        rd_data;
    logic [7:0]        mem [P_RECV_LEN];
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic              cap_full;
    logic              tx_fire;
    logic              rd_en;

    assign wr_en      = (state == RECV) && i_sam_data_vld;
    assign count_inc  = count + 13'd1;
    assign cap_full   = wr_en && !i_sam_data_last && (count_inc == RECV_LEN);
    assign tx_fire    = o_tx_valid && i_tx_ready;
    assign tx_idx_inc = tx_idx + 13'd1;
    assign o_busy     = (state != IDLE);
    assign o_tx_valid = (state != IDLE) && (state != RECV);

    // Byte 0 is loaded while the length is on the wire; each payload accept
    // fetches the next address so the stream never bubbles.
    assign rd_en   = (state == LEN_L) ||
                     ((state == DATA) && tx_fire && (tx_idx_inc != count));
    assign rd_addr = (state == DATA) ? tx_idx_inc[ADDR_W-1:0] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RECV;
            RECV:    if (wr_en && (i_sam_data_last || (count_inc == RECV_LEN))) state_nxt = HEAD0;
            HEAD0:   if (tx_fire) state_nxt = HEAD1;
            HEAD1:   if (tx_fire) state_nxt = LEN_H;
            LEN_H:   if (tx_fire) state_nxt = LEN_L;
            LEN_L:   if (tx_fire) state_nxt = DATA;
            DATA:    if (tx_fire && (tx_idx_inc == count)) state_nxt = SUM;
            SUM:     if (tx_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_tx_data = 8'h00;
        case (state)
            HEAD0:   o_tx_data = P_HEAD[15:8];
            HEAD1:   o_tx_data = P_HEAD[7:0];
            LEN_H:   o_tx_data = {3'b000, count[12:8]};
            LEN_L:   o_tx_data = count[7:0];
            DATA:    o_tx_data = rd_data;
            SUM:     o_tx_data = checksum;
            default: o_tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count       <= 13'd0;
            checksum    <= 8'h00;
            tx_idx      <= 13'd0;
            o_ovf       <= 1'b0;
            o_sam_start <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_sam_start <= (state == IDLE) && i_start;
            o_done      <= (state == SUM) && tx_fire;
            if ((state == IDLE) && i_start) begin
                count    <= 13'd0;
                checksum <= 8'h00;
                o_ovf    <= 1'b0;
            end
            if (wr_en) begin
                count    <= count_inc;
                checksum <= checksum + i_sam_data;
            end
            if (cap_full) begin
                o_ovf <= 1'b1;
            end
            if (state == LEN_L) begin
                tx_idx <= 13'd0;
            end else if ((state == DATA) && tx_fire) begin
                tx_idx <= tx_idx_inc;
            end
        end
    end

    // Capture buffer: no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[count[ADDR_W-1:0]] <= i_sam_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_sample_frame_pack.sv
// tb/tb_sample_frame_pack.sv - randomized self-checking bench for sample_frame_pack
module tb_sample_frame_pack;
    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sam_start;
    logic [7:0] sam_data = 8'h00;
    logic       vld = 1'b0;
    logic       last = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       done;
    logic       ovf;

    always #5 clk = ~clk;

    sample_frame_pack #(.P_RECV_LEN(LEN), .P_HEAD(16'h55AA)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .o_sam_start     (sam_start),
        .i_sam_data      (sam_data),
        .i_sam_data_vld  (vld),
        .i_sam_data_last (last),
        .o_tx_data       (tx_data),
        .o_tx_valid      (tx_valid),
        .i_tx_ready      (tx_ready),
        .o_busy          (busy),
        .o_done          (done),
        .o_ovf           (ovf)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] in_q[$];
    bit         last_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         exp_ovf;
    int         term_idx;
    int         term_cyc;
    int         first_cyc;
    int         last_acc_cyc;
    int         sam_pulses;
    bit         saw_done;
    int         ready_mode;
    bit         poke_start;
    bit         pat_bits[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reference: keep bytes up to the first last or until the buffer is full.
    function automatic void build_model();
        int         n = 0;
        logic [7:0] sum = 8'h00;
        logic [7:0] st[$];
        exp_ovf  = 1'b0;
        term_idx = -1;
        for (int i = 0; i < in_q.size(); i++) begin
            st.push_back(in_q[i]);
            sum = sum + in_q[i];
            n++;
            if (last_q[i]) begin
                term_idx = i;
                break;
            end
            if (n == LEN) begin
                exp_ovf  = 1'b1;
                term_idx = i;
                break;
            end
        end
        exp_q = {8'h55, 8'hAA, 8'(n >> 8), 8'(n)};
        foreach (st[i]) exp_q.push_back(st[i]);
        exp_q.push_back(sum);
    endfunction

    task automatic drive_bytes();
        for (int i = 0; i < in_q.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                vld      = 1'b0;
                last     = 1'($urandom_range(0, 1));
                sam_data = 8'($urandom);
                @(posedge clk); #1;
            end
            vld      = 1'b1;
            sam_data = in_q[i];
            last     = last_q[i];
            if (i == term_idx) term_cyc = cyc;
            @(posedge clk); #1;
        end
        vld  = 1'b0;
        last = 1'b0;
    endtask

    task automatic monitor_frame();
        bit         stalled = 1'b0;
        bit         poked = 1'b0;
        logic [7:0] held = 8'h00;
        int         pat = 0;
        got_q      = {};
        sam_pulses = 0;
        first_cyc  = -1;
        saw_done   = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (sam_start) sam_pulses++;
            if (stalled && tx_valid) chk("hold", tx_data, held);
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (got_q.size() >= 4) begin
                        tx_ready = pat_bits[pat % 4];
                        pat++;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
            endcase
            if (tx_valid && first_cyc < 0) first_cyc = cyc;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                last_acc_cyc = cyc;
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            if (poke_start && !poked && got_q.size() == 5) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int rmode, input bit poke);
        int n;
        ready_mode = rmode;
        poke_start = poke;
        build_model();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            drive_bytes();
            monitor_frame();
        join
        chk({tag, "_done_seen"}, saw_done, 1);
        chk({tag, "_sam_start_pulses"}, sam_pulses, 1);
        chk({tag, "_frame_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        chk({tag, "_first_valid_latency"}, first_cyc - term_cyc, 1);
        if (rmode == 0)
            chk({tag, "_no_bubbles"}, last_acc_cyc - first_cyc, exp_q.size() - 1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_idle_after"}, {busy, tx_valid}, 2'b00);
    endtask

    task automatic set_frame(input logic [7:0] d[$], input bit l[$]);
        in_q   = d;
        last_q = l;
    endtask

    initial begin
        int k;
        int accepted;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {sam_start, tx_valid, busy, done, ovf, tx_data}, 0);
        rst_n = 1'b1;

        set_frame('{8'h01, 8'h02, 8'h03}, '{0, 0, 1});
        run_frame("basic", 0, 0);
        set_frame('{8'h10, 8'h20, 8'h30, 8'h40, 8'h50}, '{0, 0, 0, 0, 0});
        run_frame("overflow", 0, 0);
        set_frame('{8'h01, 8'h02, 8'h03}, '{0, 0, 1});
        run_frame("stall", 2, 0);
        set_frame('{8'hFF, 8'hFF}, '{0, 1});
        run_frame("sum_wrap", 0, 0);
        set_frame('{8'h11, 8'h22, 8'h33}, '{0, 0, 1});
        run_frame("start_in_data", 0, 1);
        set_frame('{8'h44}, '{1});
        run_frame("restart", 1, 0);

        // Abort while the length low byte is stalled on the wire.
        set_frame('{8'h01, 8'h02, 8'h03}, '{0, 0, 1});
        build_model();
        tx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_bytes();
        accepted = 0;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (accepted == 3) begin
                tx_ready = 1'b0;
                break;
            end
            tx_ready = 1'b1;
            if (tx_valid) accepted++;
        end
        chk("pre_reset_accepted", accepted, 3);
        @(negedge clk);
        chk("pre_reset_len_l", {tx_valid, tx_data}, {1'b1, 8'h03});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {sam_start, tx_valid, busy, done, ovf, tx_data}, 0);
        @(negedge clk);
        chk("held_reset_outputs", {sam_start, tx_valid, busy, done, ovf, tx_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {tx_valid, busy}, 0);
        run_frame("after_reset", 0, 0);

        for (int f = 0; f < 30; f++) begin
            int         nb;
            int         lp;
            logic [7:0] d[$];
            bit         l[$];
            nb = $urandom_range(1, 6);
            lp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nb - 1) : -1;
            if (lp < 0 && nb < LEN) nb = LEN + $urandom_range(0, 2);
            for (int i = 0; i < nb; i++) begin
                d.push_back(8'($urandom));
                l.push_back((i == lp) || (i > lp && lp >= 0 && $urandom_range(0, 1) == 1));
            end
            set_frame(d, l);
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
